// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces a raw key pin, producing a clean level,
// one-cycle press/release pulses and a saturating press counter.
module key_debounce #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_in,
    input  logic             cnt_clr,
    output logic             key_level,
    output logic             key_press,
    output logic             key_release,
    output logic [CNT_W-1:0] press_cnt
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYC);
    localparam logic REL = ACTIVE_LOW;
    typedef enum logic [1:0] {IDLE, P_FILT, PRESSED, R_FILT} state_t;
    state_t r_state, w_state;
    logic [1:0] r_sync;
    logic [CW-1:0] r_cnt, w_cnt, w_inc;
    logic w_s, w_level, w_press, w_rel;
    assign w_s = r_sync[1] ^ REL;
    // counter is always 0 in IDLE/PRESSED, so the first sample of a change counts as 1
    assign w_inc = r_cnt + CW'(1);
    always_comb begin
        w_state = r_state;
        w_cnt   = '0;
        w_level = key_level;
        w_press = 1'b0;
        w_rel   = 1'b0;
        if (r_state == IDLE || r_state == P_FILT) begin
            if (!w_s) w_state = IDLE;
            else if (w_inc == LIM) begin
                w_state = PRESSED;
                w_level = 1'b1;
                w_press = 1'b1;
            end else begin
                w_state = P_FILT;
                w_cnt   = w_inc;
            end
        end else begin
            if (w_s) w_state = PRESSED;
            else if (w_inc == LIM) begin
                w_state = IDLE;
                w_level = 1'b0;
                w_rel   = 1'b1;
            end else begin
                w_state = R_FILT;
                w_cnt   = w_inc;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= {2{REL}};
            r_state     <= IDLE;
            r_cnt       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            press_cnt   <= '0;
        end else begin
            r_sync      <= {r_sync[0], key_in};
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            key_level   <= w_level;
            key_press   <= w_press;
            key_release <= w_rel;
            if (cnt_clr) press_cnt <= '0;
            else if (key_press && press_cnt != '1) press_cnt <= press_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random key stimulus on two debouncer configurations,
// checked against a sample-history model of the debounce rules.
module tb_key_debounce;
    logic clk = 1'b0, rst = 1'b0, k0 = 1'b1, k1 = 1'b0, clr = 1'b0;
    logic [1:0] lv, pr, rl;
    logic [2:0] pc0, pc1;
    int checks = 0, errors = 0;

    key_debounce #(.ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .CNT_W(3)) u0 (
        .clk(clk), .rst(rst), .key_in(k0), .cnt_clr(clr),
        .key_level(lv[0]), .key_press(pr[0]), .key_release(rl[0]), .press_cnt(pc0));
    key_debounce #(.ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(1), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .key_in(k1), .cnt_clr(clr),
        .key_level(lv[1]), .key_press(pr[1]), .key_release(rl[1]), .press_cnt(pc1));

    always #5 clk = ~clk;

    // model: per-edge history of pressed samples; the level flips once the last D
    // samples all disagree with it and all came after the previous flip
    int dcyc[2] = '{4, 1};
    bit al[2] = '{1'b1, 1'b0};
    bit kh[2][0:16383];
    bit sh[2][0:16383];
    int n = 0;
    int last[2], mc[2];
    bit ml[2], mp[2], mr[2];

    task automatic model_reset();
        n = 0;
        for (int u = 0; u < 2; u++) begin
            last[u] = 0; mc[u] = 0; ml[u] = 1'b0; mp[u] = 1'b0; mr[u] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit flip;
        n++;
        for (int u = 0; u < 2; u++) begin
            kh[u][n] = (u == 0) ? k0 : k1;
            sh[u][n] = (n >= 3) ? (kh[u][n-2] ^ al[u]) : 1'b0;
            if (clr) mc[u] = 0;
            else if (mp[u] && mc[u] < 7) mc[u]++;
            flip = (n - last[u] >= dcyc[u]);
            for (int i = n - dcyc[u] + 1; i <= n && flip; i++)
                if (sh[u][i] == ml[u]) flip = 1'b0;
            if (flip) begin
                ml[u] = !ml[u]; last[u] = n; mp[u] = ml[u]; mr[u] = !ml[u];
            end else begin
                mp[u] = 1'b0; mr[u] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @edge%0d got %0h exp %0h", tag, n, got, exp);
        end
    endtask

    task automatic check_all();
        chk("u0 level", 8'(lv[0]), 8'(ml[0]));
        chk("u0 press", 8'(pr[0]), 8'(mp[0]));
        chk("u0 release", 8'(rl[0]), 8'(mr[0]));
        chk("u0 cnt", 8'(pc0), 8'(mc[0]));
        chk("u1 level", 8'(lv[1]), 8'(ml[1]));
        chk("u1 press", 8'(pr[1]), 8'(mp[1]));
        chk("u1 release", 8'(rl[1]), 8'(mr[1]));
        chk("u1 cnt", 8'(pc1), 8'(mc[1]));
    endtask

    task automatic step(input bit a, input bit b, input bit c);
        k0 = a; k1 = b; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input bit a, input int len, input bit c);
        repeat (len) step(a, !a, c);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst level", 8'({lv, pr, rl}), 8'd0);
        chk("rst cnt", 8'({pc1, pc0}), 8'd0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        bit v;
        int len;
        do_reset();
        hold(1'b0, 2, 1'b0);
        chk("t6 no press e2", 8'(pr[1]), 8'd0);
        hold(1'b0, 1, 1'b0);
        chk("t6 press e3", 8'(pr[1]), 8'd1);
        hold(1'b0, 2, 1'b0);
        chk("t1 no press e5", 8'(pr[0]), 8'd0);
        hold(1'b0, 1, 1'b0);
        chk("t1 press e6", 8'(pr[0]), 8'd1);
        chk("t1 level e6", 8'(lv[0]), 8'd1);
        hold(1'b0, 4, 1'b0);
        chk("t1 cnt", 8'(pc0), 8'd1);
        hold(1'b1, 5, 1'b0);
        chk("t1 no release r5", 8'(rl[0]), 8'd0);
        hold(1'b1, 1, 1'b0);
        chk("t1 release r6", 8'(rl[0]), 8'd1);
        chk("t1 level r6", 8'(lv[0]), 8'd0);
        hold(1'b1, 3, 1'b0);
        hold(1'b0, 3, 1'b0); hold(1'b1, 1, 1'b0); hold(1'b0, 3, 1'b0); hold(1'b1, 8, 1'b0);
        chk("t2 bounce cnt", 8'(pc0), 8'd1);
        hold(1'b0, 10, 1'b0);
        hold(1'b1, 2, 1'b0); hold(1'b0, 1, 1'b0); hold(1'b1, 5, 1'b0);
        chk("t3 cnt", 8'(pc0), 8'd2);
        repeat (8) begin hold(1'b0, 7, 1'b0); hold(1'b1, 7, 1'b0); end
        chk("t4 sat", 8'(pc0), 8'd7);
        hold(1'b0, 7, 1'b1); hold(1'b1, 7, 1'b0);
        chk("t4 clr", 8'(pc0), 8'd0);
        hold(1'b0, 4, 1'b0);
        do_reset();
        hold(1'b0, 5, 1'b0);
        chk("t5 no press e5", 8'(pr[0]), 8'd0);
        hold(1'b0, 1, 1'b0);
        chk("t5 press e6", 8'(pr[0]), 8'd1);
        hold(1'b0, 3, 1'b0);
        do_reset();
        hold(1'b0, 6, 1'b0);
        chk("t5 re-press e6", 8'(pr[0]), 8'd1);
        hold(1'b1, 8, 1'b0);
        repeat (400) begin
            v = 1'($urandom);
            len = $urandom_range(1, 7);
            repeat (len) step(v, 1'($urandom), $urandom_range(0, 30) == 0);
            if ($urandom_range(0, 60) == 0) do_reset();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
